// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream types for the word unpacker
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int BEAT_WIDTH = 8;

endpackage

// File: rtl/fifo_word_unpacker.sv
// rtl/fifo_word_unpacker.sv - pops FIFO words and streams them out as narrow beats, LSB beat first
module fifo_word_unpacker
    import stream_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int OutWidth  = BEAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] fifoReadData,
    input  logic                 fifoEmpty,
    output logic                 fifoReadEn,
    output logic [OutWidth-1:0]  outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 outLast,
    output logic                 busy
);

    localparam int Ratio    = DataWidth / OutWidth;
    localparam int IdxWidth = $clog2(Ratio);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);

    state_e                 state_q;
    logic [DataWidth-1:0]   hold_q;
    logic [IdxWidth-1:0]    idx_q;
    logic                   at_last;
    logic                   pop;

    assign at_last = (idx_q == LastIdx);

    // Pop either from idle, or on acceptance of the final beat so words run back-to-back.
    assign pop = !fifoEmpty &&
                 ((state_q == IDLE) || (state_q == SEND && outReady && at_last));

    // The flops are held in IDLE during reset; masking here keeps the FIFO untouched too.
    assign fifoReadEn = pop && !rst;

    assign outValid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign outLast  = (state_q == SEND) && at_last;
    assign outData  = (state_q == SEND) ? hold_q[int'(idx_q) * OutWidth +: OutWidth] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
        end else if (pop) begin
            state_q <= SEND;
            hold_q  <= fifoReadData;
            idx_q   <= '0;
        end else if (state_q == SEND && outReady) begin
            if (at_last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb/tb_fifo_word_unpacker.sv - self-checking bench for fifo_word_unpacker
module tb_fifo_word_unpacker;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int R  = DW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] fifoReadData;
    logic          fifoEmpty;
    logic          fifoReadEn;
    logic [OW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          outLast;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;
    int pops     = 0;

    logic [DW-1:0] fq[$];
    logic [OW-1:0] exp_data[$];
    logic          exp_last[$];

    logic          s_valid, s_last, s_ren, s_busy;
    logic [OW-1:0] s_data;

    fifo_word_unpacker #(.DataWidth(DW), .OutWidth(OW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifoReadData (fifoReadData),
        .fifoEmpty    (fifoEmpty),
        .fifoReadEn   (fifoReadEn),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .outLast      (outLast),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_fifo();
        fifoEmpty    = (fq.size() == 0);
        fifoReadData = fifoEmpty ? DW'($urandom) : fq[0];
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        pushes++;
        for (int i = 0; i < R; i++) begin
            exp_data.push_back(OW'(w >> (i * OW)));
            exp_last.push_back(i == R - 1);
        end
        drive_fifo();
    endtask

    // One clock: sample at negedge, score accepted beats, then apply any pop after the posedge.
    task automatic cycle();
        logic [OW-1:0] ed;
        logic          el;
        @(negedge clk);
        s_valid = outValid;
        s_data  = outData;
        s_last  = outLast;
        s_ren   = fifoReadEn;
        s_busy  = busy;
        checks++;
        if (s_ren && fifoEmpty) begin
            failures++;
            $display("FAIL overread: fifoReadEn=%b while fifoEmpty=%b, required fifoReadEn=0", s_ren, fifoEmpty);
        end
        if (s_valid && outReady) begin
            checks++;
            if (exp_data.size() == 0) begin
                failures++;
                $display("FAIL extra_beat: got data=%h last=%b, required no beat", s_data, s_last);
            end else begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (s_data !== ed || s_last !== el) begin
                    failures++;
                    $display("FAIL beat: got data=%h last=%b, required data=%h last=%b", s_data, s_last, ed, el);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_ren && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        drive_fifo();
    endtask

    task automatic test_reset();
        outReady = 1'b1;
        fq.push_back(32'h55AA55AA);
        drive_fifo();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || outLast !== 1'b0 || busy !== 1'b0 || outData !== '0 || fifoReadEn !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b last=%b busy=%b data=%h ren=%b, required all 0",
                     outValid, outLast, busy, outData, fifoReadEn);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (s_ren !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: got ren=%b valid=%b, required 0 0", s_ren, s_valid);
            end
        end
        fq.delete();
        drive_fifo();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] bytes_exp[4];
        int         pops0;
        bytes_exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        pops0 = pops;
        outReady = 1'b1;
        push_word(32'hA1B2C3D4);
        cycle();
        checks++;
        if (s_ren !== 1'b1 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: got ren=%b valid=%b, required 1 0", s_ren, s_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (s_valid !== 1'b1 || s_data !== bytes_exp[i] || s_last !== (i == 3) || s_ren !== 1'b0) begin
                failures++;
                $display("FAIL single_beat%0d: got valid=%b data=%h last=%b ren=%b, required 1 %h %b 0",
                         i, s_valid, s_data, s_last, s_ren, bytes_exp[i], (i == 3));
            end
        end
        cycle();
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0 || (pops - pops0) !== 1) begin
            failures++;
            $display("FAIL single_end: got valid=%b busy=%b pops=%0d, required 0 0 1", s_valid, s_busy, pops - pops0);
        end
    endtask

    task automatic test_back_to_back();
        outReady = 1'b1;
        push_word(32'h03020100);
        push_word(32'h07060504);
        cycle();
        checks++;
        if (s_ren !== 1'b1 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pop: got ren=%b valid=%b, required 1 0", s_ren, s_valid);
        end
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (s_valid !== 1'b1 || s_data !== 8'(i) || s_last !== (i % 4 == 3) || s_ren !== (i == 3)) begin
                failures++;
                $display("FAIL b2b_beat%0d: got valid=%b data=%h last=%b ren=%b, required 1 %h %b %b",
                         i, s_valid, s_data, s_last, s_ren, 8'(i), (i % 4 == 3), (i == 3));
            end
        end
        cycle();
        checks++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got valid=%b busy=%b, required 0 0", s_valid, s_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rest[3];
        rest = '{8'h33, 8'h22, 8'h11};
        outReady = 1'b1;
        push_word(32'h11223344);
        cycle();
        cycle();
        checks++;
        if (s_valid !== 1'b1 || s_data !== 8'h44) begin
            failures++;
            $display("FAIL bp_first: got valid=%b data=%h, required 1 44", s_valid, s_data);
        end
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (s_valid !== 1'b1 || s_data !== 8'h33 || s_last !== 1'b0 || s_ren !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b ren=%b, required 1 33 0 0",
                         i, s_valid, s_data, s_last, s_ren);
            end
        end
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (s_valid !== 1'b1 || s_data !== rest[i] || s_last !== (i == 2)) begin
                failures++;
                $display("FAIL bp_resume%0d: got valid=%b data=%h last=%b, required 1 %h %b",
                         i, s_valid, s_data, s_last, rest[i], (i == 2));
            end
        end
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end: got valid=%b, required 0", s_valid);
        end
    endtask

    task automatic test_empty();
        outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (s_ren !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL empty%0d: got ren=%b valid=%b, required 0 0", i, s_ren, s_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        outReady = 1'b1;
        push_word(32'hDEADBEEF);
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || outLast !== 1'b0 || busy !== 1'b0 || fifoReadEn !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: got valid=%b last=%b busy=%b ren=%b, required 0 0 0 0",
                     outValid, outLast, busy, fifoReadEn);
        end
        exp_data.delete();
        exp_last.delete();
        fq.push_back(32'h12345678);
        drive_fifo();
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (s_ren !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_hold%0d: got ren=%b valid=%b, required 0 0", i, s_ren, s_valid);
            end
        end
        fq.delete();
        drive_fifo();
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (s_ren !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after%0d: got ren=%b valid=%b busy=%b, required 0 0 0",
                         i, s_ren, s_valid, s_busy);
            end
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int budget = 0;
        while ((pushed < 1000 || exp_data.size() > 0) && budget < 30000) begin
            if (pushed < 1000 && fq.size() < 6 && $urandom_range(0, 2) != 0) begin
                push_word($urandom);
                pushed++;
            end
            outReady = ($urandom_range(0, 3) != 0);
            cycle();
            budget++;
        end
        checks++;
        if (budget >= 30000) begin
            failures++;
            $display("FAIL random_timeout: got %0d beats outstanding after %0d cycles, required 0",
                     exp_data.size(), budget);
        end
        outReady = 1'b1;
        cycle();
        cycle();
        checks++;
        if (pops !== pushes || fq.size() !== 0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_drain: got pops=%0d pushes=%0d fifo=%0d valid=%b, required equal counts, 0, 0",
                     pops, pushes, fq.size(), s_valid);
        end
    endtask

    initial begin
        outReady = 1'b0;
        drive_fifo();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
